// File: rtl/pipe_tx_scrambler.sv
// pipe_tx_scrambler
// Transmit-side Gen1/Gen2 data scrambler feeding the PIPE data-width stage.
// Applies the X^16+X^5+X^4+X^3+1 Galois LFSR byte by byte across the active
// lanes, reseeds on COM, freezes on SKP, and bypasses for Gen3 and later.
// All outputs are registered, giving exactly one pclk of latency.

module pipe_tx_scrambler #(
  parameter int pipe_width_gen1 = 8,
  parameter int pipe_width_gen2 = 8,
  parameter int pipe_width_gen3 = 16,
  parameter int pipe_width_gen4 = 32,
  parameter int pipe_width_gen5 = 32
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [2:0]  generation,
  input  logic        scrambleDisable,
  input  logic [31:0] DataIn,
  input  logic [3:0]  DataK,
  input  logic        DataValid,
  output logic [31:0] scramblerDataOut,
  output logic [3:0]  scramblerDataK,
  output logic        scramblerDataValid
);

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [7:0]  SYM_COM   = 8'hBC;
  localparam logic [7:0]  SYM_SKP   = 8'h1C;

  // Runs one byte through the LFSR, LSB first.
  // Returns {advanced lfsr, scrambled byte}.
  function automatic logic [23:0] lfsr_byte(input logic [15:0] seed, input logic [7:0] din);
    logic [15:0] l;
    logic [7:0]  d;
    l = seed;
    d = 8'h00;
    for (int b = 0; b < 8; b++) begin
      d[b] = din[b] ^ l[15];
      l    = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return {l, d};
  endfunction

  // Number of byte lanes carried at a given generation; 0 for invalid codes.
  function automatic int active_bytes(input logic [2:0] gen);
    int n;
    case (gen)
      3'd1:    n = pipe_width_gen1 / 8;
      3'd2:    n = pipe_width_gen2 / 8;
      3'd3:    n = pipe_width_gen3 / 8;
      3'd4:    n = pipe_width_gen4 / 8;
      3'd5:    n = pipe_width_gen5 / 8;
      default: n = 0;
    endcase
    return n;
  endfunction

  logic [15:0] lfsr_r;
  logic [2:0]  prev_gen_r;

  logic [15:0] lfsr_run_s;
  logic [23:0] step_s;
  logic [7:0]  byte_s;
  logic [31:0] data_s;
  logic [3:0]  k_s;
  logic        valid_s;
  int          nbytes_s;

  // Lane-serial scrambling of the current word; LFSR state chains lane to lane.
  always_comb begin
    lfsr_run_s = (generation != prev_gen_r) ? LFSR_SEED : lfsr_r;
    step_s     = 24'h000000;
    byte_s     = 8'h00;
    data_s     = 32'h0000_0000;
    k_s        = 4'b0000;
    valid_s    = 1'b0;
    nbytes_s   = active_bytes(generation);
    case (generation)
      3'd1, 3'd2: begin
        if (DataValid) begin
          valid_s = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (i < nbytes_s) begin
              byte_s = DataIn[8*i +: 8];
              k_s[i] = DataK[i];
              if (DataK[i] && (byte_s == SYM_COM)) begin
                data_s[8*i +: 8] = byte_s;
                lfsr_run_s       = LFSR_SEED;
              end else if (DataK[i] && (byte_s == SYM_SKP)) begin
                data_s[8*i +: 8] = byte_s;
              end else if (DataK[i]) begin
                step_s           = lfsr_byte(lfsr_run_s, byte_s);
                data_s[8*i +: 8] = byte_s;
                lfsr_run_s       = step_s[23:8];
              end else begin
                step_s           = lfsr_byte(lfsr_run_s, byte_s);
                data_s[8*i +: 8] = scrambleDisable ? byte_s : step_s[7:0];
                lfsr_run_s       = step_s[23:8];
              end
            end else begin
              k_s[i] = 1'b0;
            end
          end
        end else begin
          valid_s = 1'b0;
        end
      end
      3'd3, 3'd4, 3'd5: begin
        if (DataValid) begin
          valid_s = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (i < nbytes_s) begin
              data_s[8*i +: 8] = DataIn[8*i +: 8];
              k_s[i]           = DataK[i];
            end else begin
              k_s[i] = 1'b0;
            end
          end
        end else begin
          valid_s = 1'b0;
        end
      end
      default: begin
        valid_s = 1'b0;
      end
    endcase
  end

  // Output, LFSR and previous-generation registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      lfsr_r             <= LFSR_SEED;
      prev_gen_r         <= 3'd0;
      scramblerDataOut   <= 32'h0000_0000;
      scramblerDataK     <= 4'b0000;
      scramblerDataValid <= 1'b0;
    end else begin
      lfsr_r             <= lfsr_run_s;
      prev_gen_r         <= generation;
      scramblerDataOut   <= data_s;
      scramblerDataK     <= k_s;
      scramblerDataValid <= valid_s;
    end
  end

endmodule

// File: tb/tb_pipe_tx_scrambler.sv
// Testbench for pipe_tx_scrambler: directed vectors with literal expectations
// plus randomized traffic checked against a keystream-index reference model.
`timescale 1ns/1ps

module tb_pipe_tx_scrambler;

  localparam int G1W = 32;
  localparam int G2W = 8;
  localparam int G3W = 16;
  localparam int G4W = 32;
  localparam int G5W = 32;
  localparam int KLEN = 65535;

  logic        pclk = 1'b0;
  logic        reset;
  logic [2:0]  generation;
  logic        scrambleDisable;
  logic [31:0] DataIn;
  logic [3:0]  DataK;
  logic        DataValid;
  logic [31:0] scramblerDataOut;
  logic [3:0]  scramblerDataK;
  logic        scramblerDataValid;

  int checks = 0;
  int errors = 0;

  // Keystream bytes from a fresh seed; pos = bytes consumed since last reseed.
  logic [7:0] key [KLEN];
  int         pos;
  logic [2:0] prev_gen;
  logic [31:0] exp_d;
  logic [3:0]  exp_k;
  logic        exp_v;

  pipe_tx_scrambler #(
    .pipe_width_gen1(G1W), .pipe_width_gen2(G2W), .pipe_width_gen3(G3W),
    .pipe_width_gen4(G4W), .pipe_width_gen5(G5W)
  ) dut (
    .pclk(pclk), .reset(reset), .generation(generation),
    .scrambleDisable(scrambleDisable), .DataIn(DataIn), .DataK(DataK),
    .DataValid(DataValid), .scramblerDataOut(scramblerDataOut),
    .scramblerDataK(scramblerDataK), .scramblerDataValid(scramblerDataValid)
  );

  always #5 pclk = ~pclk;

  function automatic int lanes(input logic [2:0] g);
    case (g)
      3'd1: return G1W / 8;
      3'd2: return G2W / 8;
      3'd3: return G3W / 8;
      3'd4: return G4W / 8;
      3'd5: return G5W / 8;
      default: return 0;
    endcase
  endfunction

  task automatic build_key();
    logic [15:0] l;
    logic [7:0]  b;
    l = 16'hFFFF;
    for (int n = 0; n < KLEN; n++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
        b[j] = l[15];
        l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
      end
      key[n] = b;
    end
  endtask

  // Reference: expected registered outputs for the word presented this cycle.
  task automatic model(input logic [2:0] g, input logic dis, input logic [31:0] d,
                       input logic [3:0] k, input logic v, input logic rst);
    logic [7:0] b;
    exp_d = 32'h0;
    exp_k = 4'h0;
    exp_v = 1'b0;
    if (rst) begin
      pos = 0;
      prev_gen = 3'd0;
    end else begin
      if (g != prev_gen) pos = 0;
      prev_gen = g;
      if (v && (g == 3'd1 || g == 3'd2)) begin
        exp_v = 1'b1;
        for (int i = 0; i < lanes(g); i++) begin
          b = d[8*i +: 8];
          exp_k[i] = k[i];
          if (k[i] && b == 8'hBC) begin
            exp_d[8*i +: 8] = b;
            pos = 0;
          end else if (k[i] && b == 8'h1C) begin
            exp_d[8*i +: 8] = b;
          end else begin
            exp_d[8*i +: 8] = (k[i] || dis) ? b : (b ^ key[pos]);
            pos = (pos + 1) % KLEN;
          end
        end
      end else if (v && g >= 3'd3 && g <= 3'd5) begin
        exp_v = 1'b1;
        for (int i = 0; i < lanes(g); i++) begin
          exp_d[8*i +: 8] = d[8*i +: 8];
          exp_k[i] = k[i];
        end
      end
    end
  endtask

  task automatic compare(input string name, input logic [36:0] act, input logic [36:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got v=%0b k=%b d=%h, want v=%0b k=%b d=%h", name,
               act[36], act[35:32], act[31:0], req[36], req[35:32], req[31:0]);
    end
  endtask

  // One clock: drive, advance model, then compare DUT against model.
  task automatic cycle(input logic [2:0] g, input logic dis, input logic [31:0] d,
                       input logic [3:0] k, input logic v, input logic rst);
    generation = g; scrambleDisable = dis; DataIn = d; DataK = k;
    DataValid = v; reset = rst;
    model(g, dis, d, k, v, rst);
    @(posedge pclk);
    #1;
    compare("model", {scramblerDataValid, scramblerDataK, scramblerDataOut},
            {exp_v, exp_k, exp_d});
  endtask

  task automatic lit(input string name, input logic v, input logic [3:0] k, input logic [31:0] d);
    compare(name, {scramblerDataValid, scramblerDataK, scramblerDataOut}, {v, k, d});
  endtask

  logic [7:0] zs [16] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
                          8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D};

  initial begin
    logic [2:0]  g;
    logic        dis, v, rst;
    logic [31:0] d;
    logic [3:0]  k;
    logic [7:0]  b;
    int          r;

    build_key();
    pos = 0;
    prev_gen = 3'd0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (key[i] !== zs[i]) begin
        errors++;
        $display("FAIL keystream[%0d]: got %h want %h", i, key[i], zs[i]);
      end
    end

    // Reset state.
    cycle(3'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    cycle(3'd2, 1'b0, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1);
    lit("reset_state", 1'b0, 4'h0, 32'h0);

    // Reseed sequence (width 8).
    cycle(3'd2, 1'b0, 32'hBC, 4'h1, 1'b1, 1'b0); lit("reseed_com", 1'b1, 4'h1, 32'hBC);
    cycle(3'd2, 1'b0, 32'h00, 4'h0, 1'b1, 1'b0); lit("reseed_d0", 1'b1, 4'h0, 32'hFF);
    cycle(3'd2, 1'b0, 32'h00, 4'h0, 1'b1, 1'b0); lit("reseed_d1", 1'b1, 4'h0, 32'h17);

    // Zero stream after COM.
    cycle(3'd2, 1'b0, 32'hBC, 4'h1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(3'd2, 1'b0, 32'h00, 4'h0, 1'b1, 1'b0);
      lit("zero_stream", 1'b1, 4'h0, {24'h0, zs[i]});
    end

    // SKP freeze.
    cycle(3'd2, 1'b0, 32'hBC, 4'h1, 1'b1, 1'b0); lit("skp_com", 1'b1, 4'h1, 32'hBC);
    cycle(3'd2, 1'b0, 32'h00, 4'h0, 1'b1, 1'b0); lit("skp_d0", 1'b1, 4'h0, 32'hFF);
    cycle(3'd2, 1'b0, 32'h1C, 4'h1, 1'b1, 1'b0); lit("skp_a", 1'b1, 4'h1, 32'h1C);
    cycle(3'd2, 1'b0, 32'h1C, 4'h1, 1'b1, 1'b0); lit("skp_b", 1'b1, 4'h1, 32'h1C);
    cycle(3'd2, 1'b0, 32'h00, 4'h0, 1'b1, 1'b0); lit("skp_d1", 1'b1, 4'h0, 32'h17);

    // Multi-lane at 32 bits: COM then three zeros in one word.
    cycle(3'd1, 1'b0, 32'h0000_00BC, 4'h1, 1'b1, 1'b0);
    lit("multilane", 1'b1, 4'h1, 32'hC017_FFBC);

    // Bypass and masking at Gen3 (16 bits), then back to Gen1 reseeds.
    cycle(3'd3, 1'b0, 32'hA5A5_1234, 4'hF, 1'b1, 1'b0);
    lit("bypass_mask", 1'b1, 4'h3, 32'h0000_1234);
    cycle(3'd1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    lit("gen_return", 1'b1, 4'h0, 32'h14C0_17FF);

    // Invalid generation and DataValid=0.
    cycle(3'd6, 1'b0, 32'h1234_5678, 4'h0, 1'b1, 1'b0);
    lit("invalid_gen", 1'b0, 4'h0, 32'h0);
    cycle(3'd2, 1'b0, 32'hBC, 4'h1, 1'b0, 1'b0);
    lit("not_valid", 1'b0, 4'h0, 32'h0);

    // Disable, then reset.
    cycle(3'd2, 1'b1, 32'hBC, 4'h1, 1'b1, 1'b0); lit("dis_com", 1'b1, 4'h1, 32'hBC);
    cycle(3'd2, 1'b1, 32'h55, 4'h0, 1'b1, 1'b0); lit("dis_55", 1'b1, 4'h0, 32'h55);
    cycle(3'd2, 1'b1, 32'h00, 4'h0, 1'b1, 1'b0); lit("dis_00", 1'b1, 4'h0, 32'h00);
    cycle(3'd2, 1'b0, 32'h00, 4'h0, 1'b1, 1'b0); lit("en_00", 1'b1, 4'h0, 32'hC0);
    cycle(3'd2, 1'b0, 32'h00, 4'h0, 1'b1, 1'b1); lit("reset_mid", 1'b0, 4'h0, 32'h0);
    cycle(3'd1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    lit("post_reset", 1'b1, 4'h0, 32'h14C0_17FF);

    // Randomized traffic.
    g = 3'd1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        r = $urandom_range(0, 19);
        if (r < 8) g = 3'd1;
        else if (r < 16) g = 3'd2;
        else if (r < 19) g = 3'(r - 13);
        else g = 3'($urandom_range(0, 7));
      end
      dis = ($urandom_range(0, 9) == 0);
      v   = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      d = 32'h0;
      k = 4'h0;
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 15);
        b = 8'($urandom);
        if (r == 0) begin
          b = 8'hBC; k[i] = 1'b1;
        end else if (r == 1) begin
          b = 8'h1C; k[i] = 1'b1;
        end else if (r == 2) begin
          if (b == 8'hBC || b == 8'h1C) b = 8'hF7;
          k[i] = 1'b1;
        end
        d[8*i +: 8] = b;
      end
      cycle(g, dis, d, k, v, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
